// File: rtl/alu_sched_pkg.sv
// Shared constants and FSM encoding for the round-robin ALU scheduler.
package alu_sched_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_OPW   = 3;

   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_RUNSUM = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester just after 'last' has
// the highest priority and 'last' itself the lowest. The pointer register
// lives in the parent.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW:0] w_dist;
   logic [IDW:0] w_best;

   // Pick the requester with the smallest circular distance from last+1.
   always_comb begin
      w_dist = '0;
      w_best = '1;
      idx    = '0;
      grant  = '0;
      any    = |req;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) > last) begin
            w_dist = (IDW+1)'(i) - {1'b0, last} - (IDW+1)'(1);
         end else begin
            w_dist = (IDW+1)'(i) + (IDW+1)'(NREQ) - {1'b0, last} - (IDW+1)'(1);
         end
         if (req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            idx    = IDW'(i);
         end else begin
            w_best = w_best;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         grant[i] = any && (idx == IDW'(i));
      end
   end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU between NREQ requesters.
// Optional per-requester running-sum accumulation is built when the macro
// ALU_SCHED_RUNSUM_EN is defined.
module alu_rr_sched
   import alu_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int OPW   = DEF_OPW,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*OPW-1:0]   req_op,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [OPW-1:0]        alu_op,
   input  logic [WIDTH-1:0]      alu_sum,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [OPW-1:0]   r_alu_op;
   logic             r_rsp_valid;
   logic [IDW-1:0]   r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;

   logic [NREQ-1:0]  w_grant;
   logic [IDW-1:0]   w_idx;
   logic             w_any;
   logic             w_accept;
   logic [WIDTH-1:0] w_a  [NREQ];
   logic [WIDTH-1:0] w_b  [NREQ];
   logic [OPW-1:0]   w_op [NREQ];
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [OPW-1:0]   w_sel_op;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_a[g]  = req_a[g*WIDTH +: WIDTH];
      assign w_b[g]  = req_b[g*WIDTH +: WIDTH];
      assign w_op[g] = req_op[g*OPW +: OPW];
   end

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (req_valid),
      .last  (r_last),
      .grant (w_grant),
      .idx   (w_idx),
      .any   (w_any)
   );

   assign w_sel_a  = w_a[w_idx];
   assign w_sel_b  = w_b[w_idx];
   assign w_sel_op = w_op[w_idx];
   assign w_accept = (r_state == IDLE) && w_any;

   // Next-state decode and the combinational accept strobe to requesters.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = EXEC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = RESP;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      req_ready = ((r_state == IDLE) && !rst) ? w_grant : '0;
   end

   // State register, priority pointer and the ID of the request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= IDW'(NREQ-1);
         r_id    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_last <= w_idx;
            r_id   <= w_idx;
         end
      end
   end

`ifdef ALU_SCHED_RUNSUM_EN
   logic [WIDTH-1:0] r_runsum [NREQ];
   logic             r_is_runsum;
   logic             w_sel_runsum;

   assign w_sel_runsum = (w_sel_op == OPW'(OP_RUNSUM));

   // Remember whether the accepted request accumulates into its running sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_runsum <= 1'b0;
      end else if (w_accept) begin
         r_is_runsum <= w_sel_runsum;
      end
   end

   // Per-requester running sums, updated with the ALU result at the EXEC edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) begin
            r_runsum[i] <= '0;
         end
      end else if ((r_state == EXEC) && r_is_runsum) begin
         r_runsum[r_id] <= alu_sum;
      end
   end

   // Operand registers; running-sum requests become an add onto the stored sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
      end else if (w_accept) begin
         r_alu_b <= w_sel_b;
         if (w_sel_runsum) begin
            r_alu_a  <= r_runsum[w_idx];
            r_alu_op <= OPW'(OP_ADD);
         end else begin
            r_alu_a  <= w_sel_a;
            r_alu_op <= w_sel_op;
         end
      end
   end
`else
   // Operand registers: capture the winner's operands on accept, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
      end else if (w_accept) begin
         r_alu_a  <= w_sel_a;
         r_alu_b  <= w_sel_b;
         r_alu_op <= w_sel_op;
      end
   end
`endif

   // Response channel: capture the ALU result after EXEC, hold until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else if (r_state == EXEC) begin
         r_rsp_valid <= 1'b1;
         r_rsp_id    <= r_id;
         r_rsp_data  <= alu_sum;
      end else if ((r_state == RESP) && rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched with a reference ALU and a response
// scoreboard. Define ALU_SCHED_RUNSUM_EN to exercise the running-sum build.
module tb_alu_rr_sched;

   localparam int NREQ = 4;
   localparam int W    = 16;
   localparam int OPW  = 3;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ*OPW-1:0] req_op;
   logic [W-1:0]      alu_a;
   logic [W-1:0]      alu_b;
   logic [OPW-1:0]    alu_op;
   logic [W-1:0]      alu_sum;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;

   logic [W-1:0]   tb_a  [NREQ];
   logic [W-1:0]   tb_b  [NREQ];
   logic [OPW-1:0] tb_op [NREQ];

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
   } exp_t;

   exp_t       q[$];
   int         m_phase;
   int         m_last;
   logic [W-1:0] m_rs [NREQ];
   int         n_checks;
   int         n_errors;

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req_a[g*W +: W]     = tb_a[g];
      assign req_b[g*W +: W]     = tb_b[g];
      assign req_op[g*OPW +: OPW] = tb_op[g];
   end

   function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [OPW-1:0] op);
      case (op)
         3'b001:  return a + b;
         3'b010:  return a - b;
         3'b011:  return a & b;
         3'b100:  return a | b;
         3'b101:  return a ^ b;
         default: return a;
      endcase
   endfunction

   assign alu_sum = alu_model(alu_a, alu_b, alu_op);

   alu_rr_sched #(.NREQ(NREQ), .WIDTH(W), .OPW(OPW), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_sum   (alu_sum),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_phase = 0;
      m_last  = NREQ - 1;
      q.delete();
      for (int i = 0; i < NREQ; i++) m_rs[i] = '0;
   endtask

   // One clock cycle: entered just after a negedge with inputs driven.
   task automatic tick();
      logic [NREQ-1:0] exp_ready;
      logic found;
      int w;
      exp_t e;
      #1;
      exp_ready = '0;
      found = 1'b0;
      w = 0;
      if (m_phase == 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (!found && req_valid[i]) begin
               found = 1'b1;
               w = i;
            end
         end
         if (found) exp_ready[w] = 1'b1;
      end
      n_checks++;
      if (req_ready !== exp_ready) begin
         n_errors++;
         $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
      end
      n_checks++;
      if (rsp_valid !== (m_phase == 2)) begin
         n_errors++;
         $display("FAIL rsp_valid: got %b expected %b", rsp_valid, (m_phase == 2));
      end
      if ((m_phase == 2) && rsp_ready) begin
         n_checks++;
         if (q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: got response id %0d with nothing expected", rsp_id);
         end else begin
            e = q.pop_front();
            if (rsp_id !== e.id) begin
               n_errors++;
               $display("FAIL rsp_id: got %0d expected %0d", rsp_id, e.id);
            end
            n_checks++;
            if (rsp_data !== e.data) begin
               n_errors++;
               $display("FAIL rsp_data: got %h expected %h", rsp_data, e.data);
            end
         end
      end
      case (m_phase)
         0: begin
            if (found) begin
               e.id = IDW'(w);
`ifdef ALU_SCHED_RUNSUM_EN
               if (tb_op[w] == 3'b111) begin
                  e.data = alu_model(m_rs[w], tb_b[w], 3'b001);
                  m_rs[w] = e.data;
               end else begin
                  e.data = alu_model(tb_a[w], tb_b[w], tb_op[w]);
               end
`else
               e.data = alu_model(tb_a[w], tb_b[w], tb_op[w]);
`endif
               q.push_back(e);
               m_last = w;
               m_phase = 1;
            end
         end
         1: m_phase = 2;
         2: if (rsp_ready) m_phase = 0;
         default: m_phase = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Single transaction from one requester; returns what the DUT presented.
   task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OPW-1:0] op, output logic [IDW-1:0] id,
                          output logic [W-1:0] data, output logic [OPW-1:0] op_seen);
      tb_a[idx] = a;
      tb_b[idx] = b;
      tb_op[idx] = op;
      req_valid = '0;
      req_valid[idx] = 1'b1;
      rsp_ready = 1'b1;
      tick();
      op_seen = alu_op;
      req_valid = '0;
      tick();
      id = rsp_id;
      data = rsp_data;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'b1111;
      @(negedge clk);
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      n_checks++;
      if ({alu_a, alu_b, alu_op} !== 35'd0) begin n_errors++; $display("FAIL reset_alu: got %h/%h/%h expected 0", alu_a, alu_b, alu_op); end
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== 19'd0) begin n_errors++; $display("FAIL reset_rsp: got %b/%h/%h expected 0", rsp_valid, rsp_id, rsp_data); end
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      model_reset();
   endtask

   task automatic test_single();
      logic [IDW-1:0] id;
      logic [W-1:0] data;
      logic [OPW-1:0] op_seen;
      run_one(2, 16'd5, 16'd1, 3'b001, id, data, op_seen);
      n_checks++;
      if (id !== 2'd2) begin n_errors++; $display("FAIL single_id: got %0d expected 2", id); end
      n_checks++;
      if (data !== 16'd6) begin n_errors++; $display("FAIL single_data: got %h expected 0006", data); end
   endtask

   task automatic test_rr_all();
      logic [NREQ-1:0] exp_order [6];
      int n_grants;
      int last_cyc;
      exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
      exp_order[3] = 4'b1000; exp_order[4] = 4'b0001; exp_order[5] = 4'b0010;
      do_reset();
      tb_a[0] = 16'd100;  tb_b[0] = 16'd23; tb_op[0] = 3'b001;
      tb_a[1] = 16'd50;   tb_b[1] = 16'd60; tb_op[1] = 3'b010;
      tb_a[2] = 16'h0F0F; tb_b[2] = 16'h00FF; tb_op[2] = 3'b101;
      tb_a[3] = 16'hF0F0; tb_b[3] = 16'h3C3C; tb_op[3] = 3'b011;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      n_grants = 0;
      last_cyc = -3;
      for (int c = 0; c < 18; c++) begin
         #1;
         if (req_ready != 4'b0000) begin
            n_checks++;
            if (n_grants >= 6) begin
               n_errors++;
               $display("FAIL rr_extra_grant: got %b expected no more grants", req_ready);
            end else if (req_ready !== exp_order[n_grants]) begin
               n_errors++;
               $display("FAIL rr_order: got %b expected %b", req_ready, exp_order[n_grants]);
            end
            n_checks++;
            if (c - last_cyc != 3) begin
               n_errors++;
               $display("FAIL rr_interval: got %0d expected 3", c - last_cyc);
            end
            last_cyc = c;
            n_grants++;
         end
         tick();
      end
      req_valid = '0;
      n_checks++;
      if (n_grants != 6) begin n_errors++; $display("FAIL rr_count: got %0d expected 6", n_grants); end
   endtask

   task automatic test_back_to_back_stall();
      logic [IDW-1:0] cap_id;
      logic [W-1:0] cap_data;
      tb_a[1] = 16'd10; tb_b[1] = 16'd3; tb_op[1] = 3'b010;
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      tick();
      req_valid = 4'b1111;
      tick();
      cap_id = rsp_id;
      cap_data = rsp_data;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, cap_id, cap_data}) begin
            n_errors++;
            $display("FAIL stall_hold: got %b/%0d/%h expected 1/%0d/%h", rsp_valid, rsp_id, rsp_data, cap_id, cap_data);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      req_valid = '0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL stall_release: got %b expected 0", rsp_valid); end
      n_checks++;
      if (rsp_data !== 16'd7) begin n_errors++; $display("FAIL stall_data_hold: got %h expected 0007", rsp_data); end
      tick();
   endtask

   task automatic test_reset_mid();
      tb_a[2] = 16'h1234; tb_b[2] = 16'h0001; tb_op[2] = 3'b001;
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({alu_a, alu_b, alu_op} !== 35'd0) begin n_errors++; $display("FAIL midrst_alu: got %h/%h/%h expected 0", alu_a, alu_b, alu_op); end
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !== 23'd0) begin n_errors++; $display("FAIL midrst_rsp: got %b/%0d/%h/%b expected 0", rsp_valid, rsp_id, rsp_data, req_ready); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      req_valid = 4'b1111;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_first: got %b expected 0001", req_ready); end
      tick();
      req_valid = '0;
      for (int c = 0; c < 3; c++) tick();
   endtask

   task automatic test_wrap();
      logic [IDW-1:0] id;
      logic [W-1:0] data;
      logic [OPW-1:0] op_seen;
      run_one(3, 16'hFFFF, 16'h0001, 3'b001, id, data, op_seen);
      n_checks++;
      if (data !== 16'h0000) begin n_errors++; $display("FAIL wrap_data: got %h expected 0000", data); end
   endtask

   task automatic test_runsum();
      logic [IDW-1:0] id;
      logic [W-1:0] data;
      logic [OPW-1:0] op_seen;
      logic [W-1:0] exp_d;
`ifdef ALU_SCHED_RUNSUM_EN
      for (int n = 1; n <= 3; n++) begin
         run_one(1, 16'd5, 16'd1, 3'b111, id, data, op_seen);
         exp_d = W'(n);
         n_checks++;
         if (data !== exp_d) begin n_errors++; $display("FAIL runsum_data: got %h expected %h", data, exp_d); end
         n_checks++;
         if (op_seen !== 3'b001) begin n_errors++; $display("FAIL runsum_op: got %b expected 001", op_seen); end
      end
      run_one(0, 16'd9, 16'd0, 3'b111, id, data, op_seen);
      n_checks++;
      if (data !== 16'd0) begin n_errors++; $display("FAIL runsum_other: got %h expected 0000", data); end
`else
      exp_d = 16'd5;
      run_one(1, 16'd5, 16'd1, 3'b111, id, data, op_seen);
      n_checks++;
      if (op_seen !== 3'b111) begin n_errors++; $display("FAIL passthru_op: got %b expected 111", op_seen); end
      n_checks++;
      if (data !== exp_d) begin n_errors++; $display("FAIL passthru_data: got %h expected %h", data, exp_d); end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         tb_a[i] = '0;
         tb_b[i] = '0;
         tb_op[i] = '0;
      end
      model_reset();
      @(negedge clk);
      test_reset();
      test_single();
      test_rr_all();
      test_back_to_back_stall();
      test_reset_mid();
      test_wrap();
      test_runsum();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
Round-robin scheduler that shares one combinational 16-bit ALU (operands a/b, 3-bit op, result sum) between NREQ requesters. Each requester uses a valid/ready request handshake. The block registers the winner's operands, drives the shared ALU, captures its result and returns it with the requester ID on a valid/ready response channel. It sits between the requesting datapath units and the single ALU instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 16, operand/result width
OPW, 3, ALU opcode width
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
req_op  in  NREQ*OPW  opcode, requester i at [i*OPW +: OPW]
alu_a  out  WIDTH  registered operand A to the ALU
alu_b  out  WIDTH  registered operand B to the ALU
alu_op  out  OPW  registered opcode to the ALU
alu_sum  in  WIDTH  combinational ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  index of the served requester
rsp_data  out  WIDTH  captured ALU result

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data all = 0.
  - Priority pointer last = NREQ-1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from last+1 and wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On the edge, if any req_valid: latch that requester's a/b/op into alu_a/alu_b/alu_op, latch its ID, set last=winner, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - The ALU settles on the registered operands.
  - On the edge: rsp_data<=alu_sum, rsp_id<=latched ID, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid&rsp_ready.
  - On that edge: rsp_valid<=0, go to IDLE.
  - req_ready is 0 in EXEC and RESP.
- Latency: accept at edge t; rsp_valid is high after edge t+1.
  - Minimum issue interval is 3 cycles when rsp_ready is held at 1.
- Hold behaviour: alu_a/b/op keep their last values outside EXEC. rsp_data keeps its last value after the handshake.
- Fairness: a requester holding req_valid is granted within NREQ grants.
  - A requester may drop req_valid before it is granted without any side effect.
- Arithmetic: the scheduler does no arithmetic. Wrap-around and overflow are the ALU's, modulo 2**WIDTH.
- Reset mid-operation: the in-flight transaction is discarded and no response is issued.
- Simultaneous requests: exactly one is granted per IDLE cycle. The rest wait with req_ready=0.

Optional Feature:
ALU_SCHED_RUNSUM_EN
- Defined:
  - Each requester has a WIDTH-bit running-sum register, reset to 0.
  - A request with op==OP_RUNSUM (3'b111) drives alu_a = that requester's running sum, alu_b = req_b, alu_op = OP_ADD (3'b001).
  - At the EXEC edge, alu_sum is written into both rsp_data and the running-sum register.
- Undefined: op 3'b111 is passed to the ALU unchanged, and no running-sum storage is built.

Decomposition:
- Package alu_sched_pkg contains:
  - OP_ADD=3'b001 and OP_RUNSUM=3'b111
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2
  - default WIDTH and OPW constants
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: req vector and last pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register stays in alu_rr_sched.

Test Plan:
1. After reset, req_valid=4'b0100, a=5, b=1, op=001, ALU adds, rsp_ready=1 -> req_ready=4'b0100 for one cycle; rsp_valid=1 one cycle after accept; rsp_id=2, rsp_data=6.
2. All four req_valid held at 1, rsp_ready=1 -> grant order 0,1,2,3,0,1; one response every 3 cycles.
3. rsp_ready=0 for 5 cycles while a response is pending -> rsp_valid/rsp_id/rsp_data stable; req_ready=0 throughout; completion one edge after rsp_ready rises.
4. Assert rst during EXEC -> all outputs 0 immediately (async); no response; after release with 4'b1111 valid, requester 0 is granted first.
5. a=16'hFFFF, b=1, op=001 -> rsp_data=16'h0000.
6. ALU_SCHED_RUNSUM_EN defined; requester 1 issues op=111, b=1 three times -> rsp_data 1, 2, 3; alu_op observed as 001. Requester 0's running sum stays 0.
